// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset constants, fetch FSM
// state encodings, the IF/ID record layout and small address helpers.
package mips_pkg;

    // Instruction word used for a bubble and the default reset fetch address.
    localparam logic [31:0] MIPS_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

    // Fetch FSM encodings.
    // RUN:  normal sequential fetch.
    // PEND: a redirect arrived while stalled and is parked in a register.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential successor address, wrapping modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Each edge it either loads a bubble, loads the
// freshly fetched instruction, or holds. Bubble has priority over load so a
// flush takes effect even while the stage is stalled.
module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = mips_pkg::MIPS_NOP_WORD
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    // Choose the next register contents: bubble, new fetch, or hold.
    always_comb begin
        ifid_d = ifid_q;
        if (bubble_i) begin
            ifid_d.instr    = NOP_WORD;
            ifid_d.pc_plus4 = 32'h0;
            ifid_d.valid    = 1'b0;
        end else if (load_i) begin
            ifid_d.instr    = instr_i;
            ifid_d.pc_plus4 = pc_plus4_i;
            ifid_d.valid    = 1'b1;
        end
    end

    // Register update; reset leaves a bubble in place.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ifid_q.instr    <= NOP_WORD;
            ifid_q.pc_plus4 <= 32'h0;
            ifid_q.valid    <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign instr_o    = ifid_q.instr;
    assign pc_plus4_o = ifid_q.pc_plus4;
    assign valid_o    = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect handling and the IF/ID
// register. Instruction memory is combinational and external; inst_addr is
// driven straight from the PC register so it never glitches.
//
// Control semantics: stall holds the PC (and IF/ID unless flush is set);
// a redirect seen while stalled is parked in pending_target (newest wins)
// and applied on the first unstalled edge. Every taken redirect squashes
// the word fetched in that cycle, so no delay slot exists.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::MIPS_RESET_PC,
    parameter logic [31:0] NOP_WORD = mips_pkg::MIPS_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic [0:0]  dbg_state_o,
    output logic [31:0] dbg_pending_target_o
);

    logic [31:0] pc_q, pc_d;
    logic [0:0]  state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] seq_pc;
    logic        ifid_load;
    logic        ifid_bubble;

    assign seq_pc = pc_plus4(pc_q);

    // Next PC, FSM state and parked redirect target.
    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    if (redirect_valid) begin
                        pending_d = word_align(redirect_target);
                        state_d   = ST_PEND;
                    end
                end else if (redirect_valid) begin
                    pc_d = word_align(redirect_target);
                end else begin
                    pc_d = seq_pc;
                end
            end
            ST_PEND: begin
                if (stall) begin
                    if (redirect_valid) begin
                        pending_d = word_align(redirect_target);
                    end
                end else begin
                    pc_d    = redirect_valid ? word_align(redirect_target) : pending_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // IF/ID control: any PC change other than sequential squashes the fetch.
    always_comb begin
        ifid_load   = !stall;
        ifid_bubble = flush
                    || (!stall && (redirect_valid || (state_q == ST_PEND)));
    end

    // PC, FSM state and pending target; reset discards any parked redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            state_q   <= ST_RUN;
            pending_q <= 32'h0;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    ifid_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid_reg (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .instr_i    (inst_data),
        .pc_plus4_i (seq_pc),
        .instr_o    (ifid_instr),
        .pc_plus4_o (ifid_pc_plus4),
        .valid_o    (ifid_valid)
    );

    assign inst_addr            = pc_q;
    assign dbg_state_o          = state_q;
    assign dbg_pending_target_o = pending_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: reset checks, a directed vector table, a reset
// taken while a redirect is parked, and a randomized run against a
// rule-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic [0:0]  dbg_state_o;
    logic [31:0] dbg_pending_target_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [256];

    fetch_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .stall                (stall),
        .flush                (flush),
        .redirect_valid       (redirect_valid),
        .redirect_target      (redirect_target),
        .inst_addr            (inst_addr),
        .inst_data            (inst_data),
        .ifid_instr           (ifid_instr),
        .ifid_pc_plus4        (ifid_pc_plus4),
        .ifid_valid           (ifid_valid),
        .dbg_state_o          (dbg_state_o),
        .dbg_pending_target_o (dbg_pending_target_o)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory; high address bits fold into the word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[9:2]] ^ {a[31:10], 10'b0};
    endfunction

    assign inst_data = mem_word(inst_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic rv, input logic [31:0] t);
        stall           = s;
        flush           = f;
        redirect_valid  = rv;
        redirect_target = t;
    endtask

    // Reference model: fetch address, IF/ID contents, parked redirect.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic        m_have_pend;
    logic [31:0] m_pend;

    task automatic model_step(input logic s, input logic f, input logic rv, input logic [31:0] t);
        logic [31:0] fetched;
        fetched = mem_word(m_pc);
        if (!s) begin
            if (rv || m_have_pend) begin
                m_pc = rv ? (t & ~32'h3) : m_pend;
                m_instr = NOP; m_pc4 = 0; m_valid = 0;
            end else begin
                m_pc = m_pc + 4;
                if (f) begin
                    m_instr = NOP; m_pc4 = 0; m_valid = 0;
                end else begin
                    m_instr = fetched; m_pc4 = m_pc; m_valid = 1;
                end
            end
            m_have_pend = 0;
        end else begin
            if (rv) begin
                m_have_pend = 1;
                m_pend = t & ~32'h3;
            end
            if (f) begin
                m_instr = NOP; m_pc4 = 0; m_valid = 0;
            end
        end
    endtask

    // Scoreboard: expected {pc, instr, pc4, valid} per edge.
    logic [96:0] exp_q[$];

    typedef struct {
        logic        st;
        logic        fl;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic        e_v;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [96:0] e;
        logic [31:0] e_instr;
        logic        s, f, rv;
        logic [31:0] t;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Directed sequence starting from reset (RESET_PC = 0).
        vecs[0]  = '{0, 0, 0, 32'h0,         32'h4,         32'h4,   1};
        vecs[1]  = '{0, 0, 0, 32'h0,         32'h8,         32'h8,   1};
        vecs[2]  = '{0, 0, 0, 32'h0,         32'hC,         32'hC,   1};
        vecs[3]  = '{0, 0, 1, 32'h48,        32'h48,        32'h0,   0};
        vecs[4]  = '{0, 0, 0, 32'h0,         32'h4C,        32'h4C,  1};
        vecs[5]  = '{1, 0, 1, 32'h100,       32'h4C,        32'h4C,  1};
        vecs[6]  = '{1, 0, 1, 32'h203,       32'h4C,        32'h4C,  1};
        vecs[7]  = '{0, 0, 0, 32'h0,         32'h200,       32'h0,   0};
        vecs[8]  = '{0, 1, 0, 32'h0,         32'h204,       32'h0,   0};
        vecs[9]  = '{0, 0, 0, 32'h0,         32'h208,       32'h208, 1};
        vecs[10] = '{1, 1, 0, 32'h0,         32'h208,       32'h0,   0};
        vecs[11] = '{0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,   0};
        vecs[12] = '{0, 0, 0, 32'h0,         32'h0,         32'h0,   1};
        vecs[13] = '{1, 0, 0, 32'h0,         32'h0,         32'h0,   1};
        vecs[14] = '{1, 0, 1, 32'h301,       32'h0,         32'h0,   1};

        // Asynchronous reset: outputs must settle before any clock edge.
        drive(0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check("rst_pc", inst_addr, 32'h0);
        check("rst_instr", ifid_instr, NOP);
        check("rst_pc4", ifid_pc_plus4, 32'h0);
        check("rst_valid", {31'b0, ifid_valid}, 32'h0);
        check("rst_state", {31'b0, dbg_state_o}, 32'h0);
        check("rst_pend", dbg_pending_target_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].st, vecs[i].fl, vecs[i].rv, vecs[i].tgt);
            @(posedge clk);
            #1;
            e_instr = vecs[i].e_v ? mem_word(vecs[i].e_pc4 - 32'd4) : NOP;
            check($sformatf("vec%0d_pc", i), inst_addr, vecs[i].e_pc);
            check($sformatf("vec%0d_pc4", i), ifid_pc_plus4, vecs[i].e_pc4);
            check($sformatf("vec%0d_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].e_v});
            check($sformatf("vec%0d_instr", i), ifid_instr, e_instr);
        end
        check("pend_state", {31'b0, dbg_state_o}, 32'h1);
        check("pend_target", dbg_pending_target_o, 32'h300);

        // Reset between edges while a redirect is parked.
        #3;
        reset = 1'b0;
        #1;
        check("prst_pc", inst_addr, 32'h0);
        check("prst_valid", {31'b0, ifid_valid}, 32'h0);
        check("prst_instr", ifid_instr, NOP);
        check("prst_pc4", ifid_pc_plus4, 32'h0);
        check("prst_state", {31'b0, dbg_state_o}, 32'h0);
        #3;
        drive(0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("prst_fetch_pc", inst_addr, 32'h4);
        check("prst_fetch_pc4", ifid_pc_plus4, 32'h4);
        check("prst_fetch_instr", ifid_instr, mem_word(32'h0));
        check("prst_fetch_valid", {31'b0, ifid_valid}, 32'h1);

        // Randomized run against the reference model.
        m_pc = 32'h4; m_instr = mem_word(32'h0); m_pc4 = 32'h4; m_valid = 1;
        m_have_pend = 0; m_pend = 0;
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 99) < 30);
            f  = ($urandom_range(0, 99) < 15);
            rv = ($urandom_range(0, 99) < 20);
            t  = ($urandom_range(0, 3) == 0) ? $urandom : {22'b0, $urandom_range(0, 1023)};
            drive(s, f, rv, t);
            model_step(s, f, rv, t);
            exp_q.push_back({m_pc, m_instr, m_pc4, m_valid});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("rnd%0d_pc", i), inst_addr, e[96:65]);
            check($sformatf("rnd%0d_instr", i), ifid_instr, e[64:33]);
            check($sformatf("rnd%0d_pc4", i), ifid_pc_plus4, e[32:1]);
            check($sformatf("rnd%0d_valid", i), {31'b0, ifid_valid}, {31'b0, e[0]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word loaded into IF/ID for a bubble.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  hazard unit request: hold PC and IF/ID.
REQ-006 flush  in  1  load a bubble into IF/ID at this edge.
REQ-007 redirect_valid  in  1  branch/jump/jr taken this cycle.
REQ-008 redirect_target  in  32  new fetch address; bits [1:0] ignored.
REQ-009 inst_addr  out  32  fetch address to the combinational instruction memory; equals PC register.
REQ-010 inst_data  in  32  instruction word returned in the same cycle for inst_addr.
REQ-011 ifid_instr  out  32  registered instruction for decode.
REQ-012 ifid_pc_plus4  out  32  registered PC+4 of ifid_instr.
REQ-013 ifid_valid  out  1  1 = ifid_instr is real; 0 = bubble.

Function
REQ-014 FSM states SHALL be RUN and PEND (redirect captured while stalled); PEND holds target in pending_target register.
REQ-015 PC+4 SHALL be 32-bit modulo arithmetic: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-016 PC[1:0] SHALL always be 2'b00; redirect_target[1:0] forced to 00 on load.
REQ-017 RUN, stall=0, redirect_valid=0: PC <= PC+4; IF/ID <= {inst_data, PC+4, valid=1}, or bubble if flush=1.
REQ-018 RUN, stall=0, redirect_valid=1: PC <= redirect_target; IF/ID <= bubble (no delay slot; fetched word squashed).
REQ-019 RUN, stall=1, redirect_valid=0: PC and IF/ID hold.
REQ-020 RUN, stall=1, redirect_valid=1: PC holds; pending_target <= redirect_target; state -> PEND.
REQ-021 PEND, stall=1: PC holds; a new redirect_valid overwrites pending_target (newest wins).
REQ-022 PEND, stall=0: PC <= redirect_target if redirect_valid=1 else pending_target; IF/ID <= bubble; state -> RUN.
REQ-023 flush=1 with stall=1: IF/ID <= bubble (flush overrides stall for IF/ID only); PC behaviour per REQ-019..022.
REQ-024 Bubble SHALL be {NOP_WORD, 32'h0, valid=0}.
REQ-025 Latency: instruction at address A appears on ifid_instr exactly one edge after inst_addr=A with stall=0, no redirect, no flush.
REQ-026 inst_addr SHALL be glitch-free from a register (no combinational path from any input).

Reset
REQ-027 reset=0 SHALL immediately, without a clock edge: PC=RESET_PC, ifid_instr=NOP_WORD, ifid_pc_plus4=0, ifid_valid=0, state=RUN, pending_target=0.
REQ-028 Reset asserted in PEND SHALL discard the pending redirect.
REQ-029 First edge after reset release SHALL fetch RESET_PC per REQ-017.

Structure
REQ-030 NOP_WORD, RESET_PC default, FSM state encodings in shared package mips_pkg.
REQ-031 One sub-module, ifid_reg (IF/ID register with hold/bubble controls); PC, FSM, pending register in fetch_stage.

Verification
REQ-032 Reset release, memory preloaded, stall=0 -> after 3 edges inst_addr=0x0C, ifid_pc_plus4=0x0C, ifid_instr=mem[2], ifid_valid=1.
REQ-033 At PC=0x38 redirect_valid=1, target=0x48 -> next edge inst_addr=0x48, ifid_valid=0; following edge ifid_instr=mem[18], ifid_pc_plus4=0x4C.
REQ-034 stall=1 for 2 edges, redirect 0x100 in first stall cycle -> PC held, ifid unchanged; edge after stall drops: inst_addr=0x100, ifid_valid=0.
REQ-035 In PEND redirects 0x100 then 0x200 (targets 0x203) -> after stall drops inst_addr=0x200.
REQ-036 Redirect to 0xFFFF_FFFC, run 1 edge -> inst_addr=0x0, ifid_pc_plus4=0x0, ifid_valid=1.
REQ-037 Assert reset between edges while in PEND -> outputs at reset values before next edge; after release inst_addr=RESET_PC, pending target never fetched.
